// File: rtl/dm163_column_capture.sv
// Receive-side DM163 column-link decoder: deserializes columns and commits them into an 8x8 pixel buffer.
// Link edges are acted on SYNC_STAGES+1 cycles late; 1-cycle read latency; no backpressure, so the link must respect the minimum phase width.
module dm163_column_capture #(
    parameter int PIXELS_PER_COL = 8,
    parameter int BITS_PER_PIXEL = 24,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             s_clk,
    input  logic                                             s_sda,
    input  logic                                             latch,
    input  logic [PIXELS_PER_COL-1:0]                        channel,
    input  logic                                             err_clr,
    input  logic [$clog2(PIXELS_PER_COL*PIXELS_PER_COL)-1:0] rd_addr,
    output logic [BITS_PER_PIXEL-1:0]                        rd_data,
    output logic                                             frame_captured,
    output logic [PIXELS_PER_COL-1:0]                        col_mask,
    output logic                                             len_err,
    output logic                                             onehot_err
);

    localparam int COL_BITS = PIXELS_PER_COL * BITS_PER_PIXEL;
    localparam int DEPTH    = PIXELS_PER_COL * PIXELS_PER_COL;
    localparam int CW       = $clog2(PIXELS_PER_COL);
    localparam logic [PIXELS_PER_COL-1:0] CH_ONE = PIXELS_PER_COL'(1);

    // Index SYNC_STAGES of each pipe is the extra copy used for edge detection.
    logic [SYNC_STAGES:0]      sclk_pipe;
    logic [SYNC_STAGES:0]      latch_pipe;
    logic [SYNC_STAGES-1:0]    sda_pipe;
    logic [PIXELS_PER_COL-1:0] ch_pipe [SYNC_STAGES+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe  <= '0;
            latch_pipe <= '0;
            sda_pipe   <= '0;
            for (int i = 0; i <= SYNC_STAGES; i++) ch_pipe[i] <= '0;
        end else begin
            sclk_pipe  <= {sclk_pipe[SYNC_STAGES-1:0], s_clk};
            latch_pipe <= {latch_pipe[SYNC_STAGES-1:0], latch};
            sda_pipe   <= {sda_pipe[SYNC_STAGES-2:0], s_sda};
            ch_pipe[0] <= channel;
            for (int i = 1; i <= SYNC_STAGES; i++) ch_pipe[i] <= ch_pipe[i-1];
        end
    end

    logic                      sda_s;
    logic                      sclk_rise;
    logic                      latch_fall;
    logic [PIXELS_PER_COL-1:0] ch_s;
    logic                      ch_rise;
    logic                      ch_single;
    logic [CW-1:0]             ch_idx;

    assign sda_s      = sda_pipe[SYNC_STAGES-1];
    assign sclk_rise  = sclk_pipe[SYNC_STAGES-1] & ~sclk_pipe[SYNC_STAGES];
    assign latch_fall = ~latch_pipe[SYNC_STAGES-1] & latch_pipe[SYNC_STAGES];
    assign ch_s       = ch_pipe[SYNC_STAGES-1];
    assign ch_rise    = (ch_pipe[SYNC_STAGES] == '0) && (ch_s != '0);
    assign ch_single  = (ch_s != '0) && ((ch_s & (ch_s - CH_ONE)) == '0);

    always_comb begin
        ch_idx = '0;
        for (int i = 0; i < PIXELS_PER_COL; i++)
            if (ch_s[i]) ch_idx = CW'(i);
    end

    logic [COL_BITS-1:0]       sr;
    logic [COL_BITS-1:0]       sr_next;
    logic [COL_BITS-1:0]       hold;
    logic                      hold_valid;
    logic [7:0]                bit_cnt;
    logic [7:0]                cnt_next;
    logic                      do_commit;
    logic [PIXELS_PER_COL-1:0] mask_set;

    // A shift landing in the same cycle as the latch fall must count toward that column.
    assign sr_next   = sclk_rise ? {sr[COL_BITS-2:0], sda_s} : sr;
    assign cnt_next  = (sclk_rise && bit_cnt != 8'hFF) ? bit_cnt + 8'd1 : bit_cnt;
    assign do_commit = ch_rise && ch_single && hold_valid;
    assign mask_set  = col_mask | ch_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr             <= '0;
            bit_cnt        <= '0;
            hold           <= '0;
            hold_valid     <= 1'b0;
            col_mask       <= '0;
            frame_captured <= 1'b0;
            len_err        <= 1'b0;
            onehot_err     <= 1'b0;
        end else begin
            frame_captured <= 1'b0;
            sr             <= sr_next;
            bit_cnt        <= cnt_next;
            if (err_clr) begin
                len_err    <= 1'b0;
                onehot_err <= 1'b0;
            end
            if (ch_rise && !ch_single) begin
                onehot_err <= 1'b1;
            end else if (do_commit) begin
                hold_valid <= 1'b0;
                if (mask_set == '1) begin
                    frame_captured <= 1'b1;
                    col_mask       <= '0;
                end else begin
                    col_mask <= mask_set;
                end
            end
            // Placed after the commit so a coincident capture re-arms hold_valid.
            if (latch_fall) begin
                bit_cnt <= '0;
                if (cnt_next == 8'(COL_BITS)) begin
                    hold       <= sr_next;
                    hold_valid <= 1'b1;
                end else begin
                    len_err <= 1'b1;
                end
            end
        end
    end

    logic [BITS_PER_PIXEL-1:0] buffer [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && do_commit)
            for (int p = 0; p < PIXELS_PER_COL; p++)
                buffer[{ch_idx, CW'(p)}] <= hold[p*BITS_PER_PIXEL +: BITS_PER_PIXEL];
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= buffer[rd_addr];
    end

endmodule

// File: tb/tb_dm163_column_capture.sv
// Randomized bench for dm163_column_capture: a transaction-level model of columns, commits and frames,
// compared against the DUT whenever the link is quiet, plus directed literal checks.
module tb_dm163_column_capture;

    localparam int PH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_clk = 1'b0;
    logic        s_sda = 1'b0;
    logic        latch = 1'b0;
    logic [7:0]  channel = '0;
    logic        err_clr = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [23:0] rd_data;
    logic        frame_captured;
    logic [7:0]  col_mask;
    logic        len_err;
    logic        onehot_err;

    always #5 clk = ~clk;

    dm163_column_capture #(
        .PIXELS_PER_COL(8),
        .BITS_PER_PIXEL(24),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_clk(s_clk),
        .s_sda(s_sda),
        .latch(latch),
        .channel(channel),
        .err_clr(err_clr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_captured(frame_captured),
        .col_mask(col_mask),
        .len_err(len_err),
        .onehot_err(onehot_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_bits[$];
    logic [23:0] m_hold [8];
    bit          m_hold_valid = 1'b0;
    logic [23:0] m_buf [64];
    bit          m_known [64];
    logic [7:0]  m_mask = '0;
    bit          m_len_err = 1'b0;
    bit          m_oh_err = 1'b0;
    int          m_frames = 0;
    int          dut_frames = 0;
    bit          quiet = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_latch();
        if (m_bits.size() == 192) begin
            for (int p = 0; p < 8; p++)
                for (int k = 0; k < 24; k++)
                    m_hold[p][23-k] = m_bits[(7-p)*24 + k];
            m_hold_valid = 1'b1;
        end else begin
            m_len_err = 1'b1;
        end
        m_bits.delete();
    endfunction

    function automatic bit model_commit(input logic [7:0] ch);
        int c;
        bit fr;
        fr = 1'b0;
        if ($countones(ch) > 1) begin
            m_oh_err = 1'b1;
        end else if ($countones(ch) == 1 && m_hold_valid) begin
            c = $clog2(ch);
            for (int p = 0; p < 8; p++) begin
                m_buf[c*8+p]   = m_hold[p];
                m_known[c*8+p] = 1'b1;
            end
            m_mask |= ch;
            m_hold_valid = 1'b0;
            if (m_mask == 8'hFF) begin
                m_mask = '0;
                m_frames++;
                fr = 1'b1;
            end
        end
        return fr;
    endfunction

    // Compare process: frame pulses counted every cycle, status outputs checked once the link is quiet.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_captured === 1'b1) dut_frames++;
            if (quiet) begin
                check("col_mask", col_mask, m_mask);
                check("len_err", len_err, m_len_err);
                check("onehot_err", onehot_err, m_oh_err);
                check("frame_count", dut_frames, m_frames);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick(8);
        quiet = 1'b1;
    endtask

    task automatic send_column(input logic [23:0] px [8], input int nbits, input bit coinc,
                               input logic [7:0] ch_at_latch, input bit do_latch);
        logic [191:0] v;
        quiet = 1'b0;
        for (int p = 0; p < 8; p++) v[p*24 +: 24] = px[p];
        for (int i = 0; i < nbits; i++) begin
            bit b;
            bit last;
            last = (i == nbits - 1) && coinc && do_latch;
            b = (i < 192) ? v[191-i] : 1'($urandom);
            s_clk = 1'b0;
            s_sda = b;
            if (last) latch = 1'b1;
            tick(PH);
            s_clk = 1'b1;
            if (last) begin
                latch   = 1'b0;
                channel = ch_at_latch;
            end
            m_bits.push_back(b);
            tick(PH);
        end
        if (do_latch) begin
            if (!coinc) begin
                latch = 1'b1;
                tick(PH);
                latch   = 1'b0;
                channel = ch_at_latch;
                tick(PH);
            end
            if (ch_at_latch != '0) void'(model_commit(ch_at_latch));
            model_latch();
            channel = '0;
            s_clk   = 1'b0;
            settle();
        end
    endtask

    task automatic strobe(input logic [7:0] ch);
        int c, tr, hi, f_cyc, d_cyc;
        bit fr, timing;
        logic [23:0] newv;
        quiet  = 1'b0;
        timing = 1'b0;
        tr     = 0;
        newv   = '0;
        if ($countones(ch) == 1 && m_hold_valid) begin
            c = $clog2(ch);
            for (int r = 7; r >= 0; r--)
                if (m_known[c*8+r] && m_buf[c*8+r] != m_hold[r]) begin
                    timing = 1'b1;
                    tr = r;
                end
            newv    = m_hold[tr];
            rd_addr = 6'(c*8 + tr);
        end
        fr = model_commit(ch);
        channel = ch;
        hi = 0;
        f_cyc = -1;
        d_cyc = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (frame_captured === 1'b1) begin
                hi++;
                f_cyc = k;
            end
            if (timing && d_cyc < 0 && rd_data === newv) d_cyc = k;
        end
        @(posedge clk);
        #1;
        channel = '0;
        if (fr) check("frame_pulse_width", hi, 1);
        if (fr && timing) check("frame_to_rd_data_delay", d_cyc - f_cyc, 1);
        settle();
    endtask

    task automatic clear_err();
        quiet   = 1'b0;
        err_clr = 1'b1;
        tick(1);
        err_clr   = 1'b0;
        m_len_err = 1'b0;
        m_oh_err  = 1'b0;
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_frame_captured"}, frame_captured, 0);
        check({tag, "_col_mask"}, col_mask, 0);
        check({tag, "_len_err"}, len_err, 0);
        check({tag, "_onehot_err"}, onehot_err, 0);
    endtask

    task automatic do_reset();
        quiet   = 1'b0;
        s_clk   = 1'b0;
        latch   = 1'b0;
        channel = '0;
        rst     = 1'b1;
        tick(1);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        m_bits.delete();
        m_hold_valid = 1'b0;
        m_mask       = '0;
        m_len_err    = 1'b0;
        m_oh_err     = 1'b0;
        settle();
    endtask

    task automatic read_px(input int a, output logic [23:0] d);
        rd_addr = 6'(a);
        tick(1);
        #2;
        d = rd_data;
    endtask

    task automatic sweep(input int lo, input int hi);
        logic [23:0] d;
        for (int a = lo; a <= hi; a++) begin
            read_px(a, d);
            if (m_known[a]) check($sformatf("rd_data[%0d]", a), d, m_buf[a]);
        end
    endtask

    task automatic rand_px(output logic [23:0] px [8]);
        for (int p = 0; p < 8; p++) px[p] = 24'($urandom);
    endtask

    initial begin
        #900000;
        n_bad++;
        $display("FAIL watchdog: cycle budget exhausted");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] px [8];
        logic [23:0] pa [8];
        logic [23:0] d;
        logic [7:0]  ch;
        int sel, a;

        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        tick(3);
        check_reset_outputs("por");
        rst = 1'b0;
        settle();

        // Single column into column 2
        for (int p = 0; p < 8; p++) px[p] = 24'(32'h010101 * p);
        send_column(px, 192, 1'b0, 8'h00, 1'b1);
        strobe(8'h04);
        check("single_col_mask", col_mask, 8'h04);
        check("single_len_err", len_err, 0);
        for (int r = 0; r < 8; r++) begin
            read_px(16 + r, d);
            check($sformatf("single_px%0d", r), d, 32'h010101 * r);
        end

        // Full frame, pixel value = address
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 8; p++) px[p] = 24'(c*8 + p);
            send_column(px, 192, 1'b0, 8'h00, 1'b1);
            strobe(8'(1 << c));
        end
        check("frame_col_mask", col_mask, 8'h00);
        check("frame_count_literal", dut_frames, 1);
        for (int i = 0; i < 64; i++) begin
            read_px(i, d);
            check($sformatf("frame_px%0d", i), d, i);
        end

        // Length error
        rand_px(px);
        send_column(px, 191, 1'b0, 8'h00, 1'b1);
        check("len_err_set", len_err, 1);
        strobe(8'h08);
        sweep(24, 31);
        clear_err();
        check("len_err_cleared", len_err, 0);

        // Non-one-hot channel, then commit to column 0
        rand_px(pa);
        send_column(pa, 192, 1'b0, 8'h00, 1'b1);
        strobe(8'h05);
        check("onehot_err_set", onehot_err, 1);
        sweep(0, 63);
        strobe(8'h01);
        for (int r = 0; r < 8; r++) begin
            read_px(r, d);
            check($sformatf("onehot_recommit_px%0d", r), d, pa[r]);
        end
        clear_err();

        // Last s_clk rise coincides with latch fall
        rand_px(px);
        send_column(px, 192, 1'b1, 8'h00, 1'b1);
        check("coinc_len_err", len_err, 0);
        strobe(8'h10);
        read_px(32, d);
        check("coinc_px0", d, px[0]);
        sweep(32, 39);

        // Channel rise coincides with latch fall: old hold committed, new one captured
        rand_px(pa);
        send_column(pa, 192, 1'b0, 8'h00, 1'b1);
        rand_px(px);
        send_column(px, 192, 1'b0, 8'h20, 1'b1);
        strobe(8'h40);
        for (int r = 0; r < 8; r++) begin
            read_px(40 + r, d);
            check($sformatf("chlatch_old_px%0d", r), d, pa[r]);
            read_px(48 + r, d);
            check($sformatf("chlatch_new_px%0d", r), d, px[r]);
        end

        // Reset after 100 bits, then a full column
        rand_px(px);
        send_column(px, 100, 1'b0, 8'h00, 1'b0);
        do_reset();
        rand_px(px);
        send_column(px, 192, 1'b0, 8'h00, 1'b1);
        check("post_reset_len_err", len_err, 0);
        strobe(8'h80);
        check("post_reset_col_mask", col_mask, 8'h80);
        sweep(56, 63);

        // Random frame in column order
        for (int c = 0; c < 8; c++) begin
            rand_px(px);
            send_column(px, 192, 1'($urandom), 8'h00, 1'b1);
            strobe(8'(1 << c));
        end

        // Random columns, lengths, strobes and clears
        for (int it = 0; it < 10; it++) begin
            rand_px(px);
            sel = $urandom_range(0, 5);
            send_column(px, (sel == 0) ? $urandom_range(190, 194) : 192, 1'($urandom), 8'h00, 1'b1);
            sel = $urandom_range(0, 7);
            a = $urandom_range(0, 7);
            if (sel <= 5) ch = 8'(1 << a);
            else if (sel == 6) ch = 8'((1 << a) | (1 << ((a + 1 + $urandom_range(0, 6)) % 8)));
            else ch = 8'h00;
            if (ch != 8'h00) strobe(ch);
            if ($urandom_range(0, 3) == 0) clear_err();
        end
        sweep(0, 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
